// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data access.
// Optional MEM_ARB_STATS_EN adds a saturating fetch-conflict cycle counter (conflict_cnt).
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  // Handshake: requesters hold req and operands stable until their valid pulse;
  // valid is a single-cycle completion strobe, and stall = request && !valid.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DM = 2'd1,
    BUSY_IF = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        // Data side wins; a simultaneous read+write is handled as a write.
        if (dm_re || dm_we) begin
          state_d = BUSY_DM;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          we_d    = dm_we;
          cnt_d   = LAT_INIT;
        end else if (if_req && !halt) begin
          state_d = BUSY_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          cnt_d   = LAT_INIT;
        end
      end
      BUSY_DM, BUSY_IF: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter starts at MEM_LAT on the access cycle and hits zero on the response cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    resp      = busy && (cnt_q == 4'd0);
    mem_en    = busy && (cnt_q == LAT_INIT);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_valid  = resp && (state_q == BUSY_IF);
    dm_valid  = resp && (state_q == BUSY_DM);
    if_rdata  = if_valid ? mem_rdata : '0;
    dm_rdata  = (dm_valid && !we_q) ? mem_rdata : '0;
    if_stall  = if_req && !if_valid;
    dm_stall  = (dm_re || dm_we) && !dm_valid;
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (if_stall && (state_q == BUSY_DM) && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
    conflict_cnt = conflict_q;
  end
`endif

endmodule
